shift2_arbiter: RTL and testbench



---
 rtl/shift2_arbiter_pkg.sv | 15 +
 rtl/shift2_arb_grant.sv | 25 ++
 rtl/shift2_arbiter.sv | 82 ++++++++
 tb/tb_shift2_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift2_arbiter_pkg.sv
// Shared constants for the shift2_arbiter address-unit slice.
// Port IDs, output-register state encoding and default operand width.
package shift2_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic PORT_BRANCH = 1'b0;
    localparam logic PORT_JUMP   = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/shift2_arb_grant.sv
// Combinational 2-way arbiter returning a one-hot grant.
// SHIFT2_ARB_RR_EN: ties go to the port not named by ptr; else port 0.
module shift2_arb_grant (
`ifdef SHIFT2_ARB_RR_EN
    input  logic       ptr,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
`ifdef SHIFT2_ARB_RR_EN
            2'b11:   grant = ptr ? 2'b01 : 2'b10;
`else
            2'b11:   grant = 2'b01;
`endif
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/shift2_arbiter.sv
// Shares one registered left-shift-by-2 unit between branch and jump ports.
// Define SHIFT2_ARB_RR_EN for round-robin ties; default is fixed priority.
module shift2_arbiter
    import shift2_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready
);

    state_e           state;
    logic [1:0]       grant;
    logic             can_accept;
    logic             xfer;
    logic             sel_id;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFT2_ARB_RR_EN
    logic ptr;

    shift2_arb_grant u_grant (
        .ptr   (ptr),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );
`else
    shift2_arb_grant u_grant (
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );
`endif

    assign out_valid  = (state == ST_FULL);
    assign can_accept = ~out_valid | out_ready;

    // Readies are held low during reset even though the register reads EMPTY.
    assign req0_ready = rst_n & can_accept & grant[0];
    assign req1_ready = rst_n & can_accept & grant[1];

    assign xfer     = can_accept & (|grant);
    assign sel_id   = grant[1] ? PORT_JUMP : PORT_BRANCH;
    assign sel_data = grant[1] ? req1_data : req0_data;
    assign shifted  = sel_data << 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_id   <= PORT_BRANCH;
        end else if (xfer) begin
            state    <= ST_FULL;
            out_data <= shifted;
            out_id   <= sel_id;
        end else if (can_accept) begin
            state    <= ST_EMPTY;
        end
    end

`ifdef SHIFT2_ARB_RR_EN
    // Pointer moves only when a result is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b1;
        end else if (xfer) begin
            ptr <= sel_id;
        end
    end
`endif

endmodule

// File: tb/tb_shift2_arbiter.sv
// Self-checking bench for shift2_arbiter: vector table, directed corners,
// and randomized traffic against a behavioural model.
module tb_shift2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_ready;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_id;
    int          m_last;

    shift2_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v0;
        logic [31:0] d0;
        bit          v1;
        logic [31:0] d1;
        bit          ordy;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_id;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef SHIFT2_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_data  = 0;
        m_id    = 0;
        m_last  = 1;
    endfunction

    // One clock cycle: check outputs, drive inputs, check readies, advance model.
    task automatic step(input bit v0, input logic [31:0] d0, input bit v1,
                        input logic [31:0] d1, input bit ordy, output int acc);
        bit can;
        int w;
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_id", out_id, m_id);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
        #1;
        can = !m_valid || ordy;
        w   = winner(v0, v1);
        chk("req0_ready", req0_ready, can && w == 0);
        chk("req1_ready", req1_ready, can && w == 1);
        acc = -1;
        if (can) begin
            if (w >= 0) begin
                m_valid = 1;
                m_data  = (w == 1 ? d1 : d0) * 4;
                m_id    = (w == 1);
                m_last  = w;
                acc     = w;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
        out_ready  = 0;
        rst_n      = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    vec_t vecs[9];
    bit   exp_tie[4];

    initial begin
        int acc;
        bit p0, p1;
        logic [31:0] h0, h1;

        rst_n = 0;
        req0_valid = 0; req0_data = 0;
        req1_valid = 0; req1_data = 0;
        out_ready = 0;
        model_reset();

        vecs[0] = '{1, 32'h0000_0010, 0, 32'h0, 1, 1, 32'h0000_0040, 0};
        vecs[1] = '{0, 32'h0, 1, 32'hC000_0003, 1, 1, 32'h0000_000C, 1};
        vecs[2] = '{0, 32'h0, 0, 32'h0, 1, 0, 32'h0000_000C, 1};
        vecs[3] = '{0, 32'h0, 0, 32'h0, 1, 0, 32'h0000_000C, 1};
        vecs[4] = '{1, 32'h7FFF_FFFF, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0};
        vecs[5] = '{0, 32'h0, 1, 32'h0000_0005, 0, 1, 32'hFFFF_FFFC, 0};
        vecs[6] = '{0, 32'h0, 1, 32'h0000_0005, 1, 1, 32'h0000_0014, 1};
        vecs[7] = '{0, 32'h0, 0, 32'h0, 0, 1, 32'h0000_0014, 1};
        vecs[8] = '{0, 32'h0, 0, 32'h0, 1, 0, 32'h0000_0014, 1};

`ifdef SHIFT2_ARB_RR_EN
        exp_tie = '{0, 1, 0, 1};
`else
        exp_tie = '{0, 0, 0, 0};
`endif

        repeat (2) @(posedge clk);
        do_reset();

        // table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy, acc);
            #2;
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
            chk($sformatf("vec%0d_id", i), out_id, vecs[i].e_id);
        end

        // reset while FULL and stalled
        step(1, 32'h4, 0, 32'h0, 0, acc);
        #2 chk("midfull_loaded", out_data, 32'h10);
        @(negedge clk);
        req0_valid = 1;
        out_ready  = 0;
        rst_n      = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_ready0", req0_ready, 0);
        chk("midrst_ready1", req1_ready, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1;

        // first edge after release accepts
        step(1, 32'h0000_0010, 0, 32'h0, 1, acc);
        #2 chk("first_accept", out_valid, 1);

        // backpressure with both ports waiting
        step(1, 32'h100, 0, 32'h0, 1, acc);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h200, 1, 32'h300, 0, acc);
            #2 chk($sformatf("bp_stable%0d", k), out_data, 32'h400);
        end
        step(1, 32'h200, 1, 32'h300, 1, acc);
        chk("bp_release_accept", acc >= 0, 1);
        step(0, 32'h0, 0, 32'h0, 1, acc);

        // tie behaviour from reset pointer
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 32'h20 + k, 1, 32'h40 + k, 1, acc);
            #2 chk($sformatf("tie_id%0d", k), out_id, exp_tie[k]);
        end
        step(0, 32'h0, 1, 32'h50, 1, acc);
        #2 chk("tie_drop_id", out_id, 1);
        step(0, 32'h0, 0, 32'h0, 1, acc);

        // streaming 1..8 on port 0
        for (int i = 1; i <= 8; i++) begin
            step(1, i, 0, 32'h0, 1, acc);
            #2;
            chk($sformatf("stream_valid%0d", i), out_valid, 1);
            chk($sformatf("stream_data%0d", i), out_data, 4 * i);
        end
        step(0, 32'h0, 0, 32'h0, 1, acc);

        // randomized traffic; requesters hold until accepted
        p0 = 0; p1 = 0; h0 = 0; h1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1;
                h0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1;
                h1 = $urandom;
            end
            step(p0, h0, p1, h1, $urandom_range(0, 3) != 0, acc);
            if (acc == 0) p0 = 0;
            if (acc == 1) p1 = 0;
        end
        step(0, 32'h0, 0, 32'h0, 1, acc);
        step(0, 32'h0, 0, 32'h0, 1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
